traffic_light_monitor: RTL and testbench

- Passive checker on the NS/EW light-code interface driven by the traffic light controller.
- Decodes the 2-bit light codes (RED=0, YELLOW=1, GREEN=2) into phases, tracks the phase sequence NS-green, yellow, EW-green, yellow.
- Checks legality of the code combination, the phase order and the dwell time per phase. Reports sticky errors and counts completed cycles.
- Sits beside the controller in the testbench/system; drives nothing back into the controller.

---
 rtl/traffic_light_monitor.sv | 235 +++++++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
//   Passive checker on the NS/EW light-code interface of a traffic light
//   controller. Decodes the code pair, locks onto the phase ring
//   NS-green -> yellow -> EW-green -> yellow, checks combo legality, phase
//   order and per-phase dwell. Reports a sticky error with the first error
//   code captured, a per-error pulse, and a saturating completed-cycle count.
//
//   Optional feature: define TLM_STALL_WDOG_EN to add a stall watchdog that
//   raises error 5 after WDOG_LIMIT consecutive x=0 cycles while locked.
//   Without the macro, x=0 may hold a phase indefinitely.
//
// Ports
//   clk        in   clock, rising edge
//   clear      in   synchronous active-high reset
//   NS, EW     in   2-bit light codes (0=RED, 1=YELLOW, 2=GREEN)
//   x          in   controller advance enable; dwell counts only when x=1
//   phase      out  0=SYNC, 1=NSG, 2=Y1, 3=EWG, 4=Y2
//   locked     out  phase != SYNC
//   err        out  sticky error flag
//   err_code   out  first error: 1=illegal combo, 2=bad order,
//                   3=dwell short, 4=dwell long, 5=stall
//   err_pulse  out  one-cycle pulse per detected error
//   cycles     out  completed full cycles, saturating
//
// state | meaning
// SYNC  | not locked; waiting for a change into either green
// NSG   | north-south green
// Y1    | yellow after NS green
// EWG   | east-west green
// Y2    | yellow after EW green

module traffic_light_monitor #(
  parameter int unsigned NSG_DWELL  = 31,
  parameter int unsigned YEL_DWELL  = 6,
  parameter int unsigned EWG_DWELL  = 56,
  parameter int unsigned CNT_W      = 7,
  parameter int unsigned CYC_W      = 8,
  parameter int unsigned WDOG_LIMIT = 100
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [1:0]       NS,
  input  logic [1:0]       EW,
  input  logic             x,
  output logic [2:0]       phase,
  output logic             locked,
  output logic             err,
  output logic [2:0]       err_code,
  output logic             err_pulse,
  output logic [CYC_W-1:0] cycles
);

  typedef enum logic [2:0] {
    PH_SYNC = 3'd0,
    PH_NSG  = 3'd1,
    PH_Y1   = 3'd2,
    PH_EWG  = 3'd3,
    PH_Y2   = 3'd4
  } phase_e;

  typedef enum logic [1:0] {
    C_GNS = 2'd0,
    C_YY  = 2'd1,
    C_GEW = 2'd2,
    C_ILL = 2'd3
  } combo_e;

  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_ILL   = 3'd1;
  localparam logic [2:0] E_ORDER = 3'd2;
  localparam logic [2:0] E_SHORT = 3'd3;
  localparam logic [2:0] E_LONG  = 3'd4;
`ifdef TLM_STALL_WDOG_EN
  localparam logic [2:0] E_STALL = 3'd5;
`endif

  localparam int unsigned MAX_DWELL =
    (NSG_DWELL > EWG_DWELL) ? ((NSG_DWELL > YEL_DWELL) ? NSG_DWELL : YEL_DWELL)
                            : ((EWG_DWELL > YEL_DWELL) ? EWG_DWELL : YEL_DWELL);

  // The dwell counter must represent the largest dwell plus one.
  if ((MAX_DWELL + 1) > ((2 ** CNT_W) - 1) || WDOG_LIMIT == 0) begin : g_bad_params
    $error("traffic_light_monitor: CNT_W too small or WDOG_LIMIT zero");
  end

  combo_e           code;
  combo_e           prev_q;
  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             err_q, err_d;
  logic [2:0]       err_code_q, err_code_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CYC_W-1:0] cycles_q, cycles_d;
  logic             locked_q, locked_d;

  logic [CNT_W-1:0] req_dwell;
  combo_e           legal_code;
  phase_e           legal_next;
  logic [2:0]       err_det;
  logic             changed;

`ifdef TLM_STALL_WDOG_EN
  localparam int unsigned STALL_W = $clog2(WDOG_LIMIT + 1);
  logic [STALL_W-1:0] stall_q, stall_d, stall_inc;
`endif

  always_comb begin
    unique case ({NS, EW})
      4'b1000: code = C_GNS;
      4'b0101: code = C_YY;
      4'b0010: code = C_GEW;
      default: code = C_ILL;
    endcase
  end

  assign changed = (code != prev_q);

  // Required dwell of the current phase and the only code that may follow it.
  always_comb begin
    req_dwell  = '0;
    legal_code = C_ILL;
    legal_next = PH_SYNC;
    unique case (phase_q)
      PH_NSG: begin req_dwell = CNT_W'(NSG_DWELL); legal_code = C_YY;  legal_next = PH_Y1;  end
      PH_Y1:  begin req_dwell = CNT_W'(YEL_DWELL); legal_code = C_GEW; legal_next = PH_EWG; end
      PH_EWG: begin req_dwell = CNT_W'(EWG_DWELL); legal_code = C_YY;  legal_next = PH_Y2;  end
      PH_Y2:  begin req_dwell = CNT_W'(YEL_DWELL); legal_code = C_GNS; legal_next = PH_NSG; end
      default: ;
    endcase
  end

  always_comb begin
    phase_d     = phase_q;
    dwell_d     = dwell_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    err_pulse_d = 1'b0;
    cycles_d    = cycles_q;
    err_det     = E_NONE;
`ifdef TLM_STALL_WDOG_EN
    stall_inc   = '0;
    stall_d     = '0;
`endif

    if (code == C_ILL) begin
      err_det = E_ILL;
    end else if (phase_q == PH_SYNC) begin
      // Lock only on an edge into a green; the partial phase before it is not checked.
      if (changed && code != C_YY) begin
        phase_d = (code == C_GNS) ? PH_NSG : PH_EWG;
        dwell_d = {{(CNT_W-1){1'b0}}, x};
      end
    end else if (changed) begin
      if (code != legal_code) begin
        err_det = E_ORDER;
      end else if (dwell_q != req_dwell) begin
        err_det = E_SHORT;
      end else begin
        phase_d = legal_next;
        dwell_d = {{(CNT_W-1){1'b0}}, x};
        if (phase_q == PH_Y2 && cycles_q != {CYC_W{1'b1}}) begin
          cycles_d = cycles_q + 1'b1;
        end
      end
    end else if (x) begin
      if (dwell_q == req_dwell) begin
        err_det = E_LONG;
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end

`ifdef TLM_STALL_WDOG_EN
    if (phase_q != PH_SYNC && !x) begin
      stall_inc = stall_q + 1'b1;
    end
    if (err_det == E_NONE && stall_inc == STALL_W'(WDOG_LIMIT)) begin
      err_det = E_STALL;
    end
    stall_d = stall_inc;
`endif

    if (err_det != E_NONE) begin
      err_pulse_d = 1'b1;
      err_d       = 1'b1;
      if (err_code_q == E_NONE) begin
        err_code_d = err_det;
      end
      phase_d = PH_SYNC;
      dwell_d = '0;
`ifdef TLM_STALL_WDOG_EN
      stall_d = '0;
`endif
    end

    locked_d = (phase_d != PH_SYNC);
  end

  // prev_q keeps sampling through clear so a green held across clear is
  // not treated as a fresh entry.
  always_ff @(posedge clk) begin
    prev_q <= code;
    if (clear) begin
      phase_q     <= PH_SYNC;
      dwell_q     <= '0;
      err_q       <= 1'b0;
      err_code_q  <= E_NONE;
      err_pulse_q <= 1'b0;
      cycles_q    <= '0;
      locked_q    <= 1'b0;
`ifdef TLM_STALL_WDOG_EN
      stall_q     <= '0;
`endif
    end else begin
      phase_q     <= phase_d;
      dwell_q     <= dwell_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      err_pulse_q <= err_pulse_d;
      cycles_q    <= cycles_d;
      locked_q    <= locked_d;
`ifdef TLM_STALL_WDOG_EN
      stall_q     <= stall_d;
`endif
    end
  end

  assign phase     = phase_q;
  assign locked    = locked_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign err_pulse = err_pulse_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
module tb_traffic_light_monitor;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic [1:0] NS = 2'd1;
  logic [1:0] EW = 2'd1;
  logic       x = 1'b1;
  logic [2:0] phase;
  logic       locked;
  logic       err;
  logic [2:0] err_code;
  logic       err_pulse;
  logic [7:0] cycles;

  traffic_light_monitor dut (
    .clk       (clk),
    .clear     (clear),
    .NS        (NS),
    .EW        (EW),
    .x         (x),
    .phase     (phase),
    .locked    (locked),
    .err       (err),
    .err_code  (err_code),
    .err_pulse (err_pulse),
    .cycles    (cycles)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_no = 0;

  // Reference model: ring position p=1..4 (NSG, Y1, EWG, Y2), with the code
  // that must come next and the x=1 sample count required in each phase.
  int RING_NEXT [4] = '{1, 2, 1, 0};
  int RING_REQ  [4] = '{31, 6, 56, 6};
  int m_phase, m_dwell, m_prev, m_err, m_code, m_pulse, m_cycles, m_stall;

  function automatic int decode(input logic [1:0] ns, input logic [1:0] ew);
    if (ns == 2'd2 && ew == 2'd0) return 0;
    if (ns == 2'd1 && ew == 2'd1) return 1;
    if (ns == 2'd0 && ew == 2'd2) return 2;
    return 3;
  endfunction

  task automatic model_clear(input logic [1:0] ns, input logic [1:0] ew);
    m_phase = 0; m_dwell = 0; m_err = 0; m_code = 0; m_pulse = 0;
    m_cycles = 0; m_stall = 0;
    m_prev = decode(ns, ew);
  endtask

  task automatic model_step(input logic [1:0] ns, input logic [1:0] ew, input bit xv);
    int c, e, idx;
    bit was_locked;
    c = decode(ns, ew);
    e = 0;
    was_locked = (m_phase != 0);
    if (c == 3) e = 1;
    else if (!was_locked) begin
      if (c != m_prev && c != 1) begin
        m_phase = (c == 0) ? 1 : 3;
        m_dwell = xv ? 1 : 0;
      end
    end else begin
      idx = m_phase - 1;
      if (c != m_prev) begin
        if (c != RING_NEXT[idx]) e = 2;
        else if (m_dwell != RING_REQ[idx]) e = 3;
        else begin
          if (m_phase == 4 && m_cycles < 255) m_cycles++;
          m_phase = (m_phase % 4) + 1;
          m_dwell = xv ? 1 : 0;
        end
      end else if (xv) begin
        if (m_dwell >= RING_REQ[idx]) e = 4;
        else m_dwell++;
      end
    end
`ifdef TLM_STALL_WDOG_EN
    if (was_locked && !xv) m_stall++;
    else m_stall = 0;
    if (e == 0 && m_stall >= 100) e = 5;
`endif
    m_pulse = (e != 0);
    if (e != 0) begin
      m_err = 1;
      if (m_code == 0) m_code = e;
      m_phase = 0;
      m_dwell = 0;
      m_stall = 0;
    end
    m_prev = c;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s @cycle %0d: got %0d, expected %0d", nm, cyc_no, act, exp);
    end
  endtask

  task automatic step(input bit c, input logic [1:0] ns, input logic [1:0] ew, input bit xv);
    clear = c; NS = ns; EW = ew; x = xv;
    @(posedge clk);
    cyc_no++;
    if (c) model_clear(ns, ew);
    else model_step(ns, ew, xv);
    @(negedge clk);
    chk("model_phase", int'(phase), m_phase);
    chk("model_locked", int'(locked), (m_phase != 0) ? 1 : 0);
    chk("model_err", int'(err), m_err);
    chk("model_err_code", int'(err_code), m_code);
    chk("model_err_pulse", int'(err_pulse), m_pulse);
    chk("model_cycles", int'(cycles), m_cycles);
  endtask

  typedef struct {
    bit         clr;
    logic [1:0] ns;
    logic [1:0] ew;
    bit         xv;
    int         len;
    int         ph;
    int         er;
    int         code;
    int         pl;
    int         cyc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit clr, input int ns, input int ew, input bit xv, input int len,
                     input int ph, input int er, input int code, input int pl, input int cyc);
    vec_t v;
    v.clr = clr; v.ns = 2'(ns); v.ew = 2'(ew); v.xv = xv; v.len = len;
    v.ph = ph; v.er = er; v.code = code; v.pl = pl; v.cyc = cyc;
    tbl.push_back(v);
  endtask

  int dns, dew, gpos, seg_left, r;
  bit rc, rx;

  initial begin
    // legal sequence, three full cycles
    add(1, 1,1, 1, 1,  0,0,0,0,0);
    add(0, 2,0, 1, 31, 1,0,0,0,0);
    for (int k = 1; k <= 3; k++) begin
      add(0, 1,1, 1, 6,  2,0,0,0,k-1);
      add(0, 0,2, 1, 56, 3,0,0,0,k-1);
      add(0, 1,1, 1, 6,  4,0,0,0,k-1);
      add(0, 2,0, 1, 31, 1,0,0,0,k);
    end
    // illegal combo while locked in NSG
    add(0, 2,2, 1, 1,  0,1,1,1,3);
    // bad order, then a later illegal combo keeps the first code
    add(1, 1,1, 1, 1,  0,0,0,0,0);
    add(0, 2,0, 1, 31, 1,0,0,0,0);
    add(0, 0,2, 1, 1,  0,1,2,1,0);
    add(0, 0,2, 1, 3,  0,1,2,0,0);
    add(0, 3,3, 1, 1,  0,1,2,1,0);
    // yellow left after 4 samples
    add(1, 1,1, 1, 1,  0,0,0,0,0);
    add(0, 2,0, 1, 31, 1,0,0,0,0);
    add(0, 1,1, 1, 4,  2,0,0,0,0);
    add(0, 0,2, 1, 1,  0,1,3,1,0);
    // EW green held one sample too long
    add(1, 1,1, 1, 1,  0,0,0,0,0);
    add(0, 2,0, 1, 31, 1,0,0,0,0);
    add(0, 1,1, 1, 6,  2,0,0,0,0);
    add(0, 0,2, 1, 56, 3,0,0,0,0);
    add(0, 0,2, 1, 1,  0,1,4,1,0);
    // x=0 freezes dwell mid-EWG
    add(1, 1,1, 1, 1,  0,0,0,0,0);
    add(0, 2,0, 1, 31, 1,0,0,0,0);
    add(0, 1,1, 1, 6,  2,0,0,0,0);
    add(0, 0,2, 1, 20, 3,0,0,0,0);
    add(0, 0,2, 0, 20, 3,0,0,0,0);
    add(0, 0,2, 1, 36, 3,0,0,0,0);
    add(0, 1,1, 1, 6,  4,0,0,0,0);
    add(0, 2,0, 1, 1,  1,0,0,0,1);
    // long x=0 stretch while locked
    add(1, 1,1, 1, 1,  0,0,0,0,0);
    add(0, 2,0, 1, 5,  1,0,0,0,0);
    add(0, 2,0, 0, 99, 1,0,0,0,0);
`ifdef TLM_STALL_WDOG_EN
    add(0, 2,0, 0, 1,  0,1,5,1,0);
`else
    add(0, 2,0, 0, 1,  1,0,0,0,0);
`endif
    // clear while locked with err set; re-lock needs a fresh green edge
    add(1, 1,1, 1, 1,  0,0,0,0,0);
    add(0, 2,0, 1, 31, 1,0,0,0,0);
    add(0, 2,2, 1, 1,  0,1,1,1,0);
    add(0, 1,1, 1, 1,  0,1,1,0,0);
    add(0, 2,0, 1, 5,  1,1,1,0,0);
    add(1, 2,0, 1, 1,  0,0,0,0,0);
    add(0, 2,0, 1, 5,  0,0,0,0,0);
    add(0, 1,1, 1, 1,  0,0,0,0,0);
    add(0, 2,0, 1, 1,  1,0,0,0,0);

    model_clear(2'd1, 2'd1);
    @(negedge clk);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].len; k++)
        step(tbl[i].clr, tbl[i].ns, tbl[i].ew, tbl[i].xv);
      chk($sformatf("row%0d_phase", i), int'(phase), tbl[i].ph);
      chk($sformatf("row%0d_locked", i), int'(locked), (tbl[i].ph != 0) ? 1 : 0);
      chk($sformatf("row%0d_err", i), int'(err), tbl[i].er);
      chk($sformatf("row%0d_err_code", i), int'(err_code), tbl[i].code);
      chk($sformatf("row%0d_err_pulse", i), int'(err_pulse), tbl[i].pl);
      chk($sformatf("row%0d_cycles", i), int'(cycles), tbl[i].cyc);
    end

    // cycle counter saturation: 256 completed cycles
    step(1, 2'd1, 2'd1, 1'b1);
    for (int n = 0; n < 256; n++) begin
      repeat (31) step(0, 2'd2, 2'd0, 1'b1);
      repeat (6)  step(0, 2'd1, 2'd1, 1'b1);
      repeat (56) step(0, 2'd0, 2'd2, 1'b1);
      repeat (6)  step(0, 2'd1, 2'd1, 1'b1);
    end
    step(0, 2'd2, 2'd0, 1'b1);
    chk("sat_cycles", int'(cycles), 255);
    chk("sat_err", int'(err), 0);
    chk("sat_phase", int'(phase), 1);

    // randomized mostly-legal traffic against the model
    step(1, 2'd1, 2'd1, 1'b1);
    gpos = 3; seg_left = 0; dns = 1; dew = 1;
    for (int i = 0; i < 5000; i++) begin
      rc = ($urandom_range(0, 599) == 0);
      rx = ($urandom_range(0, 11) != 0);
      if (seg_left <= 0) begin
        r = $urandom_range(0, 19);
        if (r == 0) begin
          dns = $urandom_range(0, 3);
          dew = $urandom_range(0, 3);
          seg_left = $urandom_range(1, 8);
        end else begin
          gpos = (gpos + 1) % 4;
          dns = (gpos == 0) ? 2 : (gpos == 2) ? 0 : 1;
          dew = (gpos == 0) ? 0 : (gpos == 2) ? 2 : 1;
          r = $urandom_range(0, 9);
          seg_left = RING_REQ[(gpos == 0) ? 0 : (gpos == 2) ? 2 : 1]
                     + ((r == 0) ? -1 : (r == 1) ? 1 : 0);
        end
      end
      step(rc, 2'(dns), 2'(dew), rx);
      if (rx) seg_left--;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

endmodule
